// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the RV32M multiply/divide unit.
// Optional single-cycle multiply path is enabled with MULDIV_FAST_MUL_EN.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic rs1_is_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_fast_mul.sv
// Single-cycle 33x33 signed multiplier used by the fast multiply path (MULDIV_FAST_MUL_EN).
module muldiv_fast_mul (
    input  logic signed [32:0] a,
    input  logic signed [32:0] b,
    output logic signed [65:0] p
);

    assign p = a * b;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN to resolve all multiplies in one cycle at accept.
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | 32 shift-add / restoring-divide iterations
// FIX   | sign correction and result select
// DONE  | done pulse, result valid; may accept the next request
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              sign_q, sign_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;

    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift, rem_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fast_a, fast_b;
    logic signed [65:0] fast_p;

    assign fast_a = {rs1_is_signed(op) & rs1[XLEN-1], rs1};
    assign fast_b = {rs2_is_signed(op) & rs2[XLEN-1], rs2};

    muldiv_fast_mul u_fast_mul (
        .a (fast_a),
        .b (fast_b),
        .p (fast_p)
    );
`endif

    always_comb begin
        neg_a    = rs1_is_signed(op) & rs1[XLEN-1];
        neg_b    = rs2_is_signed(op) & rs2[XLEN-1];
        mag_a    = neg_a ? -rs1 : rs1;
        mag_b    = neg_b ? -rs2 : rs2;
        div_zero = op[2] && (rs2 == '0);
        div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (rs1 == INT_MIN) && (rs2 == '1);

        // Accumulator high word plus multiplicand, carry kept for the right shift.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        rem_shift = {rem_q, acc_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, b_q};

        prod_fix = sign_q ? -acc_q : acc_q;
        quo_fix  = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sign_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start) begin
                        op_d   = op;
                        a_d    = mag_a;
                        b_d    = mag_b;
                        sign_d = (op[2] && op[1]) ? neg_a : (neg_a ^ neg_b);
                        cnt_d  = 5'd31;
                        rem_d  = '0;
                        acc_d  = op[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                        if (div_zero) begin
                            result_d = op[1] ? rs1 : DIV0_QUOT;
                            state_d  = DONE;
                        end else if (div_ovf) begin
                            result_d = op[1] ? '0 : INT_MIN;
                            state_d  = DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!op[2]) begin
                            result_d = (op == MD_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
                            state_d  = DONE;
`endif
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (!op_q[2]) begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end else if (!rem_diff[XLEN]) begin
                        rem_d = rem_diff[XLEN-1:0];
                        acc_d = {{XLEN{1'b0}}, acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[XLEN-1:0];
                        acc_d = {{XLEN{1'b0}}, acc_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == 5'd0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                FIX: begin
                    if (!op_q[2]) begin
                        result_d = (op_q == MD_MUL) ? acc_q[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                    end else begin
                        result_d = op_q[1] ? rem_fix : quo_fix;
                    end
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            op_q     <= MD_MUL;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; cycle numbers count from the start-sampling edge.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp;
    int n_err;
    int cyc;
    int busy_n;
    logic seen_done;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        if (busy === 1'b1) busy_n++;
        tick();
        cyc++;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        tick();
        start  = 1'b0;
        cyc    = 1;
        busy_n = 0;
    endtask

    task automatic wait_done(input string tag);
        while (done !== 1'b1 && cyc < 80) step();
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int lat);
        issue(o, a, b);
        wait_done(tag);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat - 1));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        rs1   = '0;
        rs2   = '0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        tick();

        // Multiplies
        run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mulh_big", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);

        // Divides
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_big_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, DIV_LAT);
        run_op("remu_big_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, DIV_LAT);

        // Special cases resolve at accept
        run_op("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Start during CALC is ignored
        issue(3'b101, 32'd100, 32'd7);
        while (cyc < 5) step();
        op    = 3'b000;
        rs1   = 32'd3;
        rs2   = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ign_start");
        check("ign_start_result", result, 32'd14);
        check("ign_start_latency", 32'(cyc), 32'd34);

        // Flush mid-operation
        issue(3'b100, 32'd1000, 32'd3);
        while (cyc < 10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_c11", 32'(busy), 32'd0);
        check("flush_done_c11", 32'(done), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            tick();
        end
        check("flush_no_done", 32'(seen_done), 32'd0);
        check("flush_result_held", result, 32'd14);

        // Back-to-back: second start in the done cycle
        run_op("b2b_first", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2);
        check("b2b_busy_c1", 32'(busy), 32'd1);
        wait_done("b2b_second");
        check("b2b_second_result", result, 32'hFFFF_FFFF);
        check("b2b_second_latency", 32'(cyc), 32'd34);

        // Flush and start together in the done cycle: request dropped
        op    = 3'b101;
        rs1   = 32'd50;
        rs2   = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        check("flush_start_done", 32'(done), 32'd0);
        check("flush_start_result", result, 32'hFFFF_FFFF);

        // Asynchronous reset mid-CALC
        issue(3'b101, 32'd100, 32'd7);
        while (cyc < 15) step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_result", result, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        run_op("post_rst_divu", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
